calu_issue_stage: RTL and testbench

//  Sequential issue/retire wrapper placed directly in front of, and behind, the combinational complex ALU.

---
 rtl/calu_issue_stage.sv | 126 ++++++++++++
 tb/tb_calu_issue_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/calu_issue_stage.sv
// Issue/retire wrapper around the combinational complex ALU: registers operands,
// waits a per-opcode settle time, captures result and flags, and keeps status.
module calu_issue_stage #(
    parameter int SETTLE        = 1,
    parameter int SETTLE_MULDIV = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_z1,
    input  logic [31:0] in_z2,
    input  logic [3:0]  in_opcode,
    output logic [31:0] calu_z1,
    output logic [31:0] calu_z2,
    output logic [3:0]  calu_opcode,
    input  logic [31:0] calu_zout,
    input  logic [11:0] calu_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_zout,
    output logic [11:0] out_flags,
    output logic [11:0] sticky_flags,
    input  logic        sticky_clr,
    output logic [7:0]  err_count,
    output logic        busy
);

    localparam int MAX_SETTLE = (SETTLE > SETTLE_MULDIV) ? SETTLE : SETTLE_MULDIV;
    localparam int CW         = (MAX_SETTLE < 2) ? 1 : $clog2(MAX_SETTLE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [31:0]     z1_reg;
    logic [31:0]     z2_reg;
    logic [3:0]      opcode_reg;
    logic [31:0]     zout_reg;
    logic [11:0]     flags_reg;
    logic [11:0]     sticky_reg;
    logic [7:0]      err_reg;

    logic            capture;
    logic            cap_err;
    logic            is_muldiv;
    logic [11:0]     sticky_base;
    logic [7:0]      err_base;

    assign is_muldiv = (in_opcode == 4'b0010) || (in_opcode == 4'b0011);
    assign capture   = (state_reg == EXEC) && (cnt_reg == CW'(1));
    // Error flags are DVFR, DVFI, ZER, ZEI.
    assign cap_err   = |calu_flags[9:6];

    // A clear coinciding with a capture wipes history first, then folds in the new result.
    assign sticky_base = sticky_clr ? 12'd0 : sticky_reg;
    assign err_base    = sticky_clr ? 8'd0  : err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            z1_reg     <= '0;
            z2_reg     <= '0;
            opcode_reg <= '0;
            zout_reg   <= '0;
            flags_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        z1_reg     <= in_z1;
                        z2_reg     <= in_z2;
                        opcode_reg <= in_opcode;
                        cnt_reg    <= is_muldiv ? CW'(SETTLE_MULDIV) : CW'(SETTLE);
                        state_reg  <= EXEC;
                    end
                end
                EXEC: begin
                    if (capture) begin
                        zout_reg  <= calu_zout;
                        flags_reg <= calu_flags;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_reg <= '0;
            err_reg    <= '0;
        end else if (capture) begin
            sticky_reg <= sticky_base | calu_flags;
            err_reg    <= (cap_err && (err_base != 8'hFF)) ? err_base + 8'd1 : err_base;
        end else if (sticky_clr) begin
            sticky_reg <= '0;
            err_reg    <= '0;
        end
    end

    assign in_ready     = (state_reg == IDLE);
    assign busy         = (state_reg != IDLE);
    assign out_valid    = (state_reg == DONE);
    assign calu_z1      = z1_reg;
    assign calu_z2      = z2_reg;
    assign calu_opcode  = opcode_reg;
    assign out_zout     = zout_reg;
    assign out_flags    = flags_reg;
    assign sticky_flags = sticky_reg;
    assign err_count    = err_reg;

endmodule

// File: tb/tb_calu_issue_stage.sv
// Directed bench for calu_issue_stage; the bench plays the ALU by driving calu_zout/calu_flags.
module tb_calu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_z1;
    logic [31:0] in_z2;
    logic [3:0]  in_opcode;
    logic [31:0] calu_z1;
    logic [31:0] calu_z2;
    logic [3:0]  calu_opcode;
    logic [31:0] calu_zout;
    logic [11:0] calu_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_zout;
    logic [11:0] out_flags;
    logic [11:0] sticky_flags;
    logic        sticky_clr;
    logic [7:0]  err_count;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    calu_issue_stage #(.SETTLE(1), .SETTLE_MULDIV(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_z1(in_z1), .in_z2(in_z2), .in_opcode(in_opcode),
        .calu_z1(calu_z1), .calu_z2(calu_z2), .calu_opcode(calu_opcode),
        .calu_zout(calu_zout), .calu_flags(calu_flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_zout(out_zout), .out_flags(out_flags),
        .sticky_flags(sticky_flags), .sticky_clr(sticky_clr),
        .err_count(err_count), .busy(busy)
    );

    typedef struct {
        logic [31:0] z1;
        logic [31:0] z2;
        logic [3:0]  op;
        logic [31:0] az;      // ALU result presented by the bench
        logic [11:0] af;      // ALU flags presented by the bench
        int          lat;     // expected edges from accept to out_valid
        logic [11:0] st;      // expected sticky_flags after capture
        logic [7:0]  err;     // expected err_count after capture
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for out_valid, check result/status; optional clear on the capture edge.
    task automatic run_op(input logic [31:0] z1, input logic [31:0] z2, input logic [3:0] op,
                          input logic [31:0] az, input logic [11:0] af, input int lat,
                          input logic [11:0] st, input logic [7:0] err, input bit clr,
                          input bit release_now, input string tag);
        int seen;
        seen = 0;
        calu_zout  = az;
        calu_flags = af;
        in_z1 = z1; in_z2 = z2; in_opcode = op; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, " in_ready_low"}, 32'(in_ready), 32'd0);
        chk({tag, " calu_z1"}, calu_z1, z1);
        chk({tag, " calu_z2"}, calu_z2, z2);
        chk({tag, " calu_opcode"}, 32'(calu_opcode), 32'(op));
        for (int i = 1; i <= 10; i++) begin
            sticky_clr = clr && (i == lat);
            tick();
            sticky_clr = 1'b0;
            if (out_valid) begin
                seen = i;
                break;
            end
        end
        chk({tag, " latency"}, 32'(seen), 32'(lat));
        chk({tag, " out_zout"}, out_zout, az);
        chk({tag, " out_flags"}, 32'(out_flags), 32'(af));
        chk({tag, " sticky"}, 32'(sticky_flags), 32'(st));
        chk({tag, " err_count"}, 32'(err_count), 32'(err));
        $display("[TB] %s op=%0h z1=%08h z2=%08h -> zout=%08h flags=%03h lat=%0d sticky=%03h err=%0d",
                 tag, op, z1, z2, out_zout, out_flags, seen, sticky_flags, err_count);
        if (release_now) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({tag, " out_valid_drop"}, 32'(out_valid), 32'd0);
            chk({tag, " in_ready_back"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int xfers;
        int cycles;
        logic [31:0] hold_z;
        logic [11:0] hold_f;

        //            z1            z2            op     az            af       lat st      err
        vecs[0] = '{32'h0003_0005, 32'h0001_0002, 4'h0, 32'h0004_0007, 12'h000, 1, 12'h000, 8'd0};
        vecs[1] = '{32'h0007_0009, 32'h0000_0000, 4'h3, 32'h0000_0000, 12'h0C0, 3, 12'h0C0, 8'd1};
        vecs[2] = '{32'h0000_0000, 32'h0001_0001, 4'h1, 32'hFFFF_FFFF, 12'hC03, 1, 12'hCC3, 8'd1};
        vecs[3] = '{32'h0002_0000, 32'h0003_0000, 4'h2, 32'h0006_0000, 12'h000, 3, 12'hCC3, 8'd1};
        vecs[4] = '{32'h1234_5678, 32'h0000_0000, 4'h4, 32'h0000_0000, 12'h030, 1, 12'hCF3, 8'd1};
        vecs[5] = '{32'h7FFF_7FFF, 32'h0001_0001, 4'hF, 32'h8000_8000, 12'h20C, 1, 12'hEFF, 8'd2};

        rst_n = 1'b0; in_valid = 1'b0; in_z1 = '0; in_z2 = '0; in_opcode = '0;
        calu_zout = '0; calu_flags = '0; out_ready = 1'b0; sticky_clr = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_zout", out_zout, 32'd0);
        chk("rst calu_z1", calu_z1, 32'd0);
        chk("rst err_count", 32'(err_count), 32'd0);

        for (int v = 0; v < 6; v++) begin
            run_op(vecs[v].z1, vecs[v].z2, vecs[v].op, vecs[v].az, vecs[v].af, vecs[v].lat,
                   vecs[v].st, vecs[v].err, 1'b0, 1'b1, $sformatf("vec%0d", v));
        end

        // Operands keep their values while idle.
        tick();
        chk("idle calu_z1 held", calu_z1, 32'h7FFF_7FFF);

        // Clear alone.
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("clr sticky", 32'(sticky_flags), 32'd0);
        chk("clr err", 32'(err_count), 32'd0);
        $display("[TB] sticky_clr alone -> sticky=%03h err=%0d", sticky_flags, err_count);

        // Sticky accumulation, then clear colliding with a capture.
        run_op(32'h0000_0000, 32'h0001_0001, 4'h1, 32'hFFFF_FFFF, 12'hC03, 1, 12'hC03, 8'd0, 1'b0, 1'b1, "csub");
        run_op(32'h0000_0000, 32'h0000_0000, 4'h4, 32'h0000_0000, 12'h030, 1, 12'hC33, 8'd0, 1'b0, 1'b1, "cand");
        run_op(32'h0000_0000, 32'h0000_0000, 4'h4, 32'h0000_0000, 12'h030, 1, 12'h030, 8'd0, 1'b1, 1'b1, "cand_clr");
        run_op(32'h0005_0005, 32'h0000_0000, 4'h3, 32'h0000_0000, 12'h0C0, 3, 12'h0C0, 8'd1, 1'b1, 1'b1, "cdiv_clr");

        // Backpressure: hold result while a new request and ALU noise are present.
        run_op(32'h0003_0005, 32'h0001_0002, 4'h0, 32'h0004_0007, 12'h000, 1, 12'h0C0, 8'd1, 1'b0, 1'b0, "bp");
        hold_z = out_zout;
        hold_f = out_flags;
        in_z1 = 32'hDEAD_BEEF; in_z2 = 32'h1111_2222; in_opcode = 4'h5; in_valid = 1'b1;
        calu_zout = 32'hAAAA_5555; calu_flags = 12'hFFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d in_ready", i), 32'(in_ready), 32'd0);
            chk($sformatf("bp%0d zout", i), out_zout, hold_z);
            chk($sformatf("bp%0d flags", i), 32'(out_flags), 32'(hold_f));
        end
        chk("bp calu_z1 not taken", calu_z1, 32'h0003_0005);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp released out_valid", 32'(out_valid), 32'd0);
        chk("bp released in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("bp single transfer", 32'(out_valid), 32'd0);
        $display("[TB] backpressure 5 cycles -> zout=%08h flags=%03h", hold_z, hold_f);

        // Reset during a CMUL settle.
        calu_zout = 32'h0006_0000; calu_flags = 12'h000;
        in_z1 = 32'h0002_0000; in_z2 = 32'h0003_0000; in_opcode = 4'h2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mulrst busy before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mulrst in_ready", 32'(in_ready), 32'd1);
        chk("mulrst calu_z1", calu_z1, 32'd0);
        chk("mulrst calu_opcode", 32'(calu_opcode), 32'd0);
        chk("mulrst out_zout", out_zout, 32'd0);
        chk("mulrst sticky", 32'(sticky_flags), 32'd0);
        chk("mulrst err", 32'(err_count), 32'd0);
        xfers = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) xfers++;
        end
        chk("mulrst no out_valid", 32'(xfers), 32'd0);
        $display("[TB] reset during CMUL -> in_ready=%0d out_valid_count=%0d", in_ready, xfers);

        // Saturation: 260 back-to-back CDIV by zero.
        calu_zout = 32'h0; calu_flags = 12'h0C0;
        in_z1 = 32'h0001_0001; in_z2 = 32'h0; in_opcode = 4'h3;
        in_valid = 1'b1; out_ready = 1'b1;
        xfers = 0;
        cycles = 0;
        while (xfers < 260 && cycles < 4000) begin
            tick();
            cycles++;
            if (out_valid) begin
                xfers++;
                if (xfers == 100) chk("sat err@100", 32'(err_count), 32'd100);
                if (xfers == 255) chk("sat err@255", 32'(err_count), 32'd255);
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("sat transfers", 32'(xfers), 32'd260);
        chk("sat err final", 32'(err_count), 32'd255);
        chk("sat sticky", 32'(sticky_flags), 32'h0C0);
        $display("[TB] saturation %0d ops -> err_count=%0d", xfers, err_count);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
